// File: rtl/note_sequencer.sv
// note_sequencer
//   Step sequencer sitting between the SPI config block and the voice
//   (oscillator + ADSR). It holds a STEPS-deep pattern of note periods, each
//   with a rest flag. It advances through that pattern at a programmable
//   tempo and drives osc_count/trig. When it is not running, it forwards the
//   SPI-supplied osc_count/trig to the voice, one cycle late.
//
// Ports
//   clk, arstn       clock, asynchronous active-low reset
//   progn            low while an SPI frame is in progress (forces idle)
//   seq_en           1 = play the pattern, 0 = passthrough
//   tempo_div        clocks per step minus 1
//   gate_len         clocks trig stays high at the start of each step
//   last_step        final step index; the sequence wraps to 0 after it
//   wr_en/wr_addr/wr_note/wr_rest   pattern write port
//   man_osc_count/man_trig          passthrough values from SPI
//   osc_count, trig  registered voice controls
//   step             current step index
//   step_pulse       one-cycle pulse at the start of every step
//   busy             high while sequencing
module note_sequencer #(
  parameter int STEPS   = 8,
  parameter int ADDR_W  = 3,
  parameter int TEMPO_W = 16
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               progn,
  input  logic               seq_en,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [ADDR_W-1:0]  last_step,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [11:0]        wr_note,
  input  logic               wr_rest,
  input  logic [11:0]        man_osc_count,
  input  logic               man_trig,
  output logic [11:0]        osc_count,
  output logic               trig,
  output logic [ADDR_W-1:0]  step,
  output logic               step_pulse,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, GATE, WAIT} state_t;

  state_t             state, state_next;
  logic [TEMPO_W-1:0] cnt, cnt_next, cnt_inc;
  logic [ADDR_W-1:0]  step_next, step_inc;
  logic [11:0]        osc_next;
  logic               trig_next, pulse_next, busy_next;
  logic               run, step_end;

  logic [11:0]        note_mem [STEPS];
  logic [STEPS-1:0]   rest_mem;

  // An SPI frame in progress has the same effect as disabling the sequencer.
  assign run      = seq_en & progn;
  assign step_end = (cnt == tempo_div);
  assign cnt_inc  = cnt + 1'b1;
  // A step index at or beyond last_step wraps to 0. This also covers the
  // case where last_step is lowered below the current step.
  assign step_inc = (step >= last_step) ? '0 : step + 1'b1;

  // Pattern storage. The write commits on the clock edge, so a step start
  // reading the same address in that cycle still sees the old contents.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < STEPS; i++) note_mem[i] <= '0;
      rest_mem <= '1;
    end else if (wr_en) begin
      note_mem[wr_addr] <= wr_note;
      rest_mem[wr_addr] <= wr_rest;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      cnt        <= '0;
      step       <= '0;
      osc_count  <= '0;
      trig       <= 1'b0;
      step_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      step       <= step_next;
      osc_count  <= osc_next;
      trig       <= trig_next;
      step_pulse <= pulse_next;
      busy       <= busy_next;
    end
  end

  // Next-state and output logic. trig is computed from the count value that
  // will hold during the coming cycle, so a step is gated for exactly
  // gate_len clocks. The step start does not close the gate, so gate_len
  // larger than the step length gives legato across non-rest steps.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    step_next  = step;
    osc_next   = osc_count;
    trig_next  = trig;
    pulse_next = 1'b0;
    busy_next  = busy;

    case (state)
      IDLE: begin
        if (run) begin
          state_next = GATE;
          cnt_next   = '0;
          step_next  = '0;
          osc_next   = note_mem[0];
          trig_next  = ~rest_mem[0] & (gate_len != '0);
          pulse_next = 1'b1;
          busy_next  = 1'b1;
        end else begin
          step_next = '0;
          osc_next  = man_osc_count;
          trig_next = man_trig;
          busy_next = 1'b0;
        end
      end

      GATE, WAIT: begin
        if (!run) begin
          // trig drops on this edge. Passthrough resumes from IDLE on the
          // following edge.
          state_next = IDLE;
          cnt_next   = '0;
          step_next  = '0;
          trig_next  = 1'b0;
          busy_next  = 1'b0;
        end else if (step_end) begin
          state_next = GATE;
          cnt_next   = '0;
          step_next  = step_inc;
          osc_next   = note_mem[step_inc];
          trig_next  = ~rest_mem[step_inc] & (gate_len != '0);
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
          if (state == GATE && cnt_inc < gate_len) begin
            trig_next = ~rest_mem[step];
          end else begin
            state_next = WAIT;
            trig_next  = 1'b0;
          end
        end
      end

      default: begin
        state_next = IDLE;
        trig_next  = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule
